// File: rtl/pll_reconfig_ctrl.sv
// PLL reconfiguration / lock-qualification controller.
// Sequences PLL reset, waits for lock with timeout and bounded retries,
// qualifies lock stability, then runs. New divider sets are accepted in
// RUN or FAIL.
// Ports:
//   clock_in, reset          : single clock, synchronous active-high reset
//   cfg_valid/cfg_ready      : divider-set handshake, cfg_*sel payload
//   pll_locked               : raw PLL lock (asynchronous)
//   pll_reset, pll_*sel      : PLL control outputs
//   clock_ok, user_reset     : qualified-clock status and downstream reset
//   error, lock_lost         : lock acquisition failure / sticky loss flag
//   retry_count              : failed attempts in the current sequence
module pll_reconfig_ctrl #(
    parameter int unsigned RESET_CYCLES        = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 100000,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter logic [5:0]  DEF_IDSEL           = 6'd60,
    parameter logic [5:0]  DEF_FBDSEL          = 6'd63,
    parameter logic [5:0]  DEF_ODSEL           = 6'd48
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [5:0] cfg_idsel,
    input  logic [5:0] cfg_fbdsel,
    input  logic [5:0] cfg_odsel,
    input  logic       pll_locked,
    output logic       pll_reset,
    output logic [5:0] pll_idsel,
    output logic [5:0] pll_fbdsel,
    output logic [5:0] pll_odsel,
    output logic       clock_ok,
    output logic       user_reset,
    output logic       error,
    output logic       lock_lost,
    output logic [1:0] retry_count
);

    localparam int unsigned RST_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int unsigned TO_W     = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;
    localparam int unsigned STB_W    = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
    localparam int unsigned RST_LAST = (RESET_CYCLES > 0) ? RESET_CYCLES - 1 : 0;
    localparam int unsigned TO_LAST  = (LOCK_TIMEOUT_CYCLES > 0) ? LOCK_TIMEOUT_CYCLES - 1 : 0;
    // The lock_s=1 cycle that leaves WAIT_LOCK is the first stable cycle,
    // so QUALIFY needs LOCK_STABLE_CYCLES-1 more.
    localparam int unsigned STB_LAST = (LOCK_STABLE_CYCLES > 1) ? LOCK_STABLE_CYCLES - 2 : 0;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        QUALIFY   = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [RST_W-1:0] rst_cnt, rst_cnt_nxt;
    logic [TO_W-1:0]  to_cnt, to_cnt_nxt;
    logic [STB_W-1:0] stb_cnt, stb_cnt_nxt;
    logic [1:0]       retry_nxt;
    logic [5:0]       idsel_nxt, fbdsel_nxt, odsel_nxt;
    logic             pll_reset_nxt, clock_ok_nxt, error_nxt, lock_lost_nxt;
    logic             cfg_ready_nxt, user_reset_nxt;
    logic             take;
    logic             lock_meta, lock_s;

    // Two-flop lock synchronizer
    always_ff @(posedge clock_in) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
        end
    end

    // State and output registers
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state       <= PLL_RST;
            rst_cnt     <= '0;
            to_cnt      <= '0;
            stb_cnt     <= '0;
            retry_count <= 2'd0;
            pll_reset   <= 1'b1;
            pll_idsel   <= DEF_IDSEL;
            pll_fbdsel  <= DEF_FBDSEL;
            pll_odsel   <= DEF_ODSEL;
            clock_ok    <= 1'b0;
            user_reset  <= 1'b1;
            cfg_ready   <= 1'b0;
            error       <= 1'b0;
            lock_lost   <= 1'b0;
        end else begin
            state       <= state_nxt;
            rst_cnt     <= rst_cnt_nxt;
            to_cnt      <= to_cnt_nxt;
            stb_cnt     <= stb_cnt_nxt;
            retry_count <= retry_nxt;
            pll_reset   <= pll_reset_nxt;
            pll_idsel   <= idsel_nxt;
            pll_fbdsel  <= fbdsel_nxt;
            pll_odsel   <= odsel_nxt;
            clock_ok    <= clock_ok_nxt;
            user_reset  <= user_reset_nxt;
            cfg_ready   <= cfg_ready_nxt;
            error       <= error_nxt;
            lock_lost   <= lock_lost_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt     = state;
        rst_cnt_nxt   = rst_cnt;
        to_cnt_nxt    = to_cnt;
        stb_cnt_nxt   = stb_cnt;
        retry_nxt     = retry_count;
        pll_reset_nxt = pll_reset;
        idsel_nxt     = pll_idsel;
        fbdsel_nxt    = pll_fbdsel;
        odsel_nxt     = pll_odsel;
        clock_ok_nxt  = clock_ok;
        error_nxt     = error;
        lock_lost_nxt = lock_lost;
        take          = 1'b0;

        case (state)
            PLL_RST: begin
                pll_reset_nxt = 1'b1;
                if (rst_cnt == RST_W'(RST_LAST)) begin
                    state_nxt     = WAIT_LOCK;
                    rst_cnt_nxt   = '0;
                    to_cnt_nxt    = '0;
                    pll_reset_nxt = 1'b0;
                end else begin
                    rst_cnt_nxt = rst_cnt + RST_W'(1);
                end
            end
            WAIT_LOCK: begin
                pll_reset_nxt = 1'b0;
                // Saturating: QUALIFY can hand back an already-expired count
                to_cnt_nxt = (to_cnt >= TO_W'(TO_LAST)) ? to_cnt : to_cnt + TO_W'(1);
                if (lock_s) begin
                    stb_cnt_nxt = '0;
                    if (LOCK_STABLE_CYCLES <= 1) begin
                        state_nxt    = RUN;
                        clock_ok_nxt = 1'b1;
                        retry_nxt    = 2'd0;
                    end else begin
                        state_nxt = QUALIFY;
                    end
                end else if (to_cnt >= TO_W'(TO_LAST)) begin
                    pll_reset_nxt = 1'b1;
                    if (retry_count < 2'(MAX_RETRIES)) begin
                        retry_nxt   = retry_count + 2'd1;
                        rst_cnt_nxt = '0;
                        state_nxt   = PLL_RST;
                    end else begin
                        error_nxt = 1'b1;
                        state_nxt = FAIL;
                    end
                end
            end
            QUALIFY: begin
                to_cnt_nxt = (to_cnt >= TO_W'(TO_LAST)) ? to_cnt : to_cnt + TO_W'(1);
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                end else if (stb_cnt == STB_W'(STB_LAST)) begin
                    state_nxt    = RUN;
                    clock_ok_nxt = 1'b1;
                    retry_nxt    = 2'd0;
                end else begin
                    stb_cnt_nxt = stb_cnt + STB_W'(1);
                end
            end
            RUN: begin
                // Lock loss wins over a concurrent transfer
                if (!lock_s) begin
                    lock_lost_nxt = 1'b1;
                    clock_ok_nxt  = 1'b0;
                    retry_nxt     = 2'd0;
                    rst_cnt_nxt   = '0;
                    pll_reset_nxt = 1'b1;
                    state_nxt     = PLL_RST;
                end else begin
                    take = cfg_valid & cfg_ready;
                end
            end
            FAIL: begin
                pll_reset_nxt = 1'b1;
                error_nxt     = 1'b1;
                clock_ok_nxt  = 1'b0;
                take          = cfg_valid & cfg_ready;
            end
            default: begin
                state_nxt     = PLL_RST;
                rst_cnt_nxt   = '0;
                pll_reset_nxt = 1'b1;
                clock_ok_nxt  = 1'b0;
            end
        endcase

        // Accepted divider set: latch selects and restart the sequence
        if (take) begin
            idsel_nxt     = cfg_idsel;
            fbdsel_nxt    = cfg_fbdsel;
            odsel_nxt     = cfg_odsel;
            clock_ok_nxt  = 1'b0;
            error_nxt     = 1'b0;
            lock_lost_nxt = 1'b0;
            retry_nxt     = 2'd0;
            rst_cnt_nxt   = '0;
            pll_reset_nxt = 1'b1;
            state_nxt     = PLL_RST;
        end

        // lock_meta is what lock_s becomes next cycle, so ready drops in the
        // same cycle RUN will see the lock loss
        cfg_ready_nxt  = (state_nxt == FAIL) || ((state_nxt == RUN) && lock_meta);
        user_reset_nxt = !(clock_ok && clock_ok_nxt);
    end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Scoreboard bench for pll_reconfig_ctrl: stimulus pushes timed expectations,
// a negedge monitor compares them against the DUT outputs.
module tb_pll_reconfig_ctrl;

    localparam int S_PLL_RESET  = 0;
    localparam int S_IDSEL      = 1;
    localparam int S_FBDSEL     = 2;
    localparam int S_ODSEL      = 3;
    localparam int S_CLOCK_OK   = 4;
    localparam int S_USER_RESET = 5;
    localparam int S_CFG_READY  = 6;
    localparam int S_ERROR      = 7;
    localparam int S_LOCK_LOST  = 8;
    localparam int S_RETRY      = 9;

    typedef struct {
        int unsigned cyc;
        int          sig;
        logic [7:0]  val;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [5:0] cfg_idsel, cfg_fbdsel, cfg_odsel;
    logic       pll_locked;
    logic       pll_reset;
    logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
    logic       clock_ok, user_reset, error, lock_lost;
    logic [1:0] retry_count;

    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    exp_t        sb[$];

    pll_reconfig_ctrl #(
        .RESET_CYCLES        (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (50),
        .MAX_RETRIES         (2)
    ) dut (
        .clock_in    (clk),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_idsel   (cfg_idsel),
        .cfg_fbdsel  (cfg_fbdsel),
        .cfg_odsel   (cfg_odsel),
        .pll_locked  (pll_locked),
        .pll_reset   (pll_reset),
        .pll_idsel   (pll_idsel),
        .pll_fbdsel  (pll_fbdsel),
        .pll_odsel   (pll_odsel),
        .clock_ok    (clock_ok),
        .user_reset  (user_reset),
        .error       (error),
        .lock_lost   (lock_lost),
        .retry_count (retry_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] sample(input int s);
        case (s)
            S_PLL_RESET:  return {7'd0, pll_reset};
            S_IDSEL:      return {2'd0, pll_idsel};
            S_FBDSEL:     return {2'd0, pll_fbdsel};
            S_ODSEL:      return {2'd0, pll_odsel};
            S_CLOCK_OK:   return {7'd0, clock_ok};
            S_USER_RESET: return {7'd0, user_reset};
            S_CFG_READY:  return {7'd0, cfg_ready};
            S_ERROR:      return {7'd0, error};
            S_LOCK_LOST:  return {7'd0, lock_lost};
            S_RETRY:      return {6'd0, retry_count};
            default:      return 8'hff;
        endcase
    endfunction

    function automatic string sig_name(input int s);
        case (s)
            S_PLL_RESET:  return "pll_reset";
            S_IDSEL:      return "pll_idsel";
            S_FBDSEL:     return "pll_fbdsel";
            S_ODSEL:      return "pll_odsel";
            S_CLOCK_OK:   return "clock_ok";
            S_USER_RESET: return "user_reset";
            S_CFG_READY:  return "cfg_ready";
            S_ERROR:      return "error";
            S_LOCK_LOST:  return "lock_lost";
            S_RETRY:      return "retry_count";
            default:      return "unknown";
        endcase
    endfunction

    // Monitor: compare every expectation due at this cycle
    always @(negedge clk) begin
        exp_t       keep[$];
        logic [7:0] got;
        keep = {};
        foreach (sb[i]) begin
            if (sb[i].cyc == cyc) begin
                checks++;
                got = sample(sb[i].sig);
                if (got !== sb[i].val) begin
                    failures++;
                    $display("FAIL %s at cycle %0d: got %0d, expected %0d",
                             sig_name(sb[i].sig), cyc, got, sb[i].val);
                end
            end else if (sb[i].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL %s at cycle %0d: expectation missed, expected %0d",
                         sig_name(sb[i].sig), sb[i].cyc, sb[i].val);
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
    end

    // Expect signal s to read v after `off` more rising edges
    task automatic ex(input int unsigned off, input int s, input int v);
        exp_t e;
        e.cyc = cyc + off;
        e.sig = s;
        e.val = 8'(v);
        sb.push_back(e);
    endtask

    task automatic ex_sel(input int unsigned off, input int i, input int f, input int o);
        ex(off, S_IDSEL, i);
        ex(off, S_FBDSEL, f);
        ex(off, S_ODSEL, o);
    endtask

    task automatic ex_reset_vals(input int unsigned off);
        ex(off, S_PLL_RESET, 1);
        ex_sel(off, 60, 63, 48);
        ex(off, S_CLOCK_OK, 0);
        ex(off, S_USER_RESET, 1);
        ex(off, S_CFG_READY, 0);
        ex(off, S_ERROR, 0);
        ex(off, S_LOCK_LOST, 0);
        ex(off, S_RETRY, 0);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        cfg_valid  = 1'b0;
        cfg_idsel  = 6'd0;
        cfg_fbdsel = 6'd0;
        cfg_odsel  = 6'd0;
        pll_locked = 1'b0;
        tick(3);
        ex_reset_vals(1);
        tick(1);

        // Reset release: 4-cycle pll_reset, lock rises 10 cycles later
        reset = 1'b0;
        ex(1, S_PLL_RESET, 1);
        ex(3, S_PLL_RESET, 1);
        ex(4, S_PLL_RESET, 0);
        ex(4, S_CLOCK_OK, 0);
        tick(10);
        pll_locked = 1'b1;
        ex(9, S_CLOCK_OK, 0);
        ex(9, S_CFG_READY, 0);
        ex(10, S_CLOCK_OK, 1);
        ex(10, S_CFG_READY, 1);
        ex(10, S_USER_RESET, 1);
        ex(11, S_USER_RESET, 0);
        ex(10, S_RETRY, 0);
        tick(13);

        // Transfer {10,20,30} in RUN
        cfg_valid  = 1'b1;
        cfg_idsel  = 6'd10;
        cfg_fbdsel = 6'd20;
        cfg_odsel  = 6'd30;
        ex_sel(1, 10, 20, 30);
        ex(1, S_CLOCK_OK, 0);
        ex(1, S_USER_RESET, 1);
        ex(1, S_CFG_READY, 0);
        ex(1, S_PLL_RESET, 1);
        ex(4, S_PLL_RESET, 1);
        ex(5, S_PLL_RESET, 0);
        ex(12, S_CLOCK_OK, 0);
        ex(13, S_CLOCK_OK, 1);
        ex(13, S_LOCK_LOST, 0);
        ex(13, S_ERROR, 0);
        tick(1);
        cfg_valid  = 1'b0;
        cfg_idsel  = 6'd1;
        cfg_fbdsel = 6'd2;
        cfg_odsel  = 6'd3;
        ex_sel(3, 10, 20, 30);
        ex_sel(12, 10, 20, 30);
        tick(15);

        // Lock loss concurrent with cfg_valid, then retries into FAIL
        pll_locked = 1'b0;
        ex(1, S_CFG_READY, 1);
        ex(2, S_CFG_READY, 0);
        ex(3, S_CFG_READY, 0);
        ex(2, S_CLOCK_OK, 1);
        ex(3, S_CLOCK_OK, 0);
        ex(3, S_USER_RESET, 1);
        ex(2, S_LOCK_LOST, 0);
        ex(3, S_LOCK_LOST, 1);
        ex(2, S_PLL_RESET, 0);
        ex(3, S_PLL_RESET, 1);
        ex(6, S_PLL_RESET, 1);
        ex(7, S_PLL_RESET, 0);
        ex_sel(3, 10, 20, 30);
        ex_sel(5, 10, 20, 30);
        ex(3, S_RETRY, 0);
        ex(56, S_PLL_RESET, 0);
        ex(57, S_PLL_RESET, 1);
        ex(60, S_PLL_RESET, 1);
        ex(61, S_PLL_RESET, 0);
        ex(56, S_RETRY, 0);
        ex(57, S_RETRY, 1);
        ex(110, S_RETRY, 1);
        ex(111, S_RETRY, 2);
        ex(110, S_PLL_RESET, 0);
        ex(111, S_PLL_RESET, 1);
        ex(114, S_PLL_RESET, 1);
        ex(115, S_PLL_RESET, 0);
        ex(164, S_ERROR, 0);
        ex(165, S_ERROR, 1);
        ex(164, S_PLL_RESET, 0);
        ex(165, S_PLL_RESET, 1);
        ex(164, S_CFG_READY, 0);
        ex(165, S_CFG_READY, 1);
        ex(165, S_RETRY, 2);
        ex(165, S_CLOCK_OK, 0);
        ex(170, S_ERROR, 1);
        ex(170, S_PLL_RESET, 1);
        ex(170, S_LOCK_LOST, 1);
        tick(2);
        cfg_valid  = 1'b1;
        cfg_idsel  = 6'd7;
        cfg_fbdsel = 6'd7;
        cfg_odsel  = 6'd7;
        tick(2);
        cfg_valid = 1'b0;
        tick(168);

        // Transfer {5,6,7} out of FAIL
        cfg_valid  = 1'b1;
        cfg_idsel  = 6'd5;
        cfg_fbdsel = 6'd6;
        cfg_odsel  = 6'd7;
        ex_sel(1, 5, 6, 7);
        ex(1, S_ERROR, 0);
        ex(1, S_LOCK_LOST, 0);
        ex(1, S_RETRY, 0);
        ex(1, S_PLL_RESET, 1);
        ex(1, S_CFG_READY, 0);
        ex(4, S_PLL_RESET, 1);
        ex(5, S_PLL_RESET, 0);
        tick(1);
        cfg_valid = 1'b0;
        tick(7);

        // Lock with a 2-cycle glitch at stable count 5
        pll_locked = 1'b1;
        ex(10, S_CLOCK_OK, 0);
        ex(16, S_CLOCK_OK, 0);
        ex(17, S_CLOCK_OK, 1);
        ex(17, S_CFG_READY, 1);
        ex(17, S_USER_RESET, 1);
        ex(18, S_USER_RESET, 0);
        tick(5);
        pll_locked = 1'b0;
        tick(2);
        pll_locked = 1'b1;
        tick(13);

        // Lock loss, relock, reset asserted mid-QUALIFY
        pll_locked = 1'b0;
        ex(2, S_CLOCK_OK, 1);
        ex(3, S_CLOCK_OK, 0);
        ex(3, S_LOCK_LOST, 1);
        ex(3, S_USER_RESET, 1);
        ex(7, S_PLL_RESET, 0);
        ex(11, S_PLL_RESET, 0);
        ex(11, S_CLOCK_OK, 0);
        ex(11, S_LOCK_LOST, 1);
        ex_sel(11, 5, 6, 7);
        tick(3);
        pll_locked = 1'b1;
        tick(8);
        reset = 1'b1;
        ex_reset_vals(1);
        ex_reset_vals(2);
        tick(2);
        reset = 1'b0;
        ex(3, S_PLL_RESET, 1);
        ex(4, S_PLL_RESET, 0);
        ex(11, S_CLOCK_OK, 0);
        ex(12, S_CLOCK_OK, 1);
        tick(14);

        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
